// File: rtl/ffm_pm_if.sv
// Request/response bundle for the pseudo-Mersenne field arithmetic unit.
// The master issues operations; the slave (the arithmetic unit) returns tagged results.
interface ffm_pm_if #(
  parameter int W     = 255,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, op, a, b, tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  in_valid, op, a, b, tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/ffm_pm.sv
// Modular MUL/SQR/ADD/SUB over P = 2^W - C with a digit-serial multiplier,
// two pseudo-Mersenne folds and a final conditional-subtraction loop.
module ffm_pm #(
  parameter int W     = 255,
  parameter int C     = 19,
  parameter int DIGIT = 16,
  parameter int TAG_W = 4
) (
  input logic     clk,
  input logic     rst,
  ffm_pm_if.slave bus
);

  localparam int N     = (W + DIGIT - 1) / DIGIT;
  localparam int ACC_W = 2 * W;
  localparam int CW    = $clog2(C + 1);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ACC_W-1:0] P_ACC  = (ACC_W'(1) << W) - ACC_W'(C);
  localparam logic [ACC_W-1:0] P2_ACC = P_ACC << 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_FOLD1, S_FOLD2, S_ADDSUB, S_REDUCE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [W+DIGIT-1:0] pp;
  logic [ACC_W-1:0]   mul_term;
  logic [W+CW-1:0]    fold_hi;
  logic [ACC_W-1:0]   fold_sum;
  logic [ACC_W-1:0]   addsub;

  // b_q is shifted down one digit per MUL cycle, so its low slice is always the current digit.
  always_comb begin
    pp       = (W+DIGIT)'(a_q) * (W+DIGIT)'(b_q[DIGIT-1:0]);
    mul_term = ACC_W'(pp) << (DIGIT * int'(cnt_q));
    fold_hi  = (W+CW)'(acc_q[ACC_W-1:W]) * (W+CW)'(C);
    fold_sum = ACC_W'(acc_q[W-1:0]) + ACC_W'(fold_hi);
    addsub   = sub_q ? (ACC_W'(a_q) + P2_ACC - ACC_W'(b_q))
                     : (ACC_W'(a_q) + ACC_W'(b_q));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.op == 2'b01) ? bus.a : bus.b;
          sub_d   = bus.op[0];
          tag_d   = bus.tag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = bus.op[1] ? S_ADDSUB : S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + mul_term;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = S_FOLD1;
      end
      S_FOLD1: begin
        acc_d   = fold_sum;
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        acc_d   = fold_sum;
        state_d = S_REDUCE;
      end
      S_ADDSUB: begin
        acc_d   = addsub;
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (acc_q >= P_ACC) begin
          acc_d = acc_q - P_ACC;
        end else begin
          result_d    = acc_q[W-1:0];
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      tag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_ffm_pm.sv
// Directed and random checks of ffm_pm against a wide-integer mod-P reference,
// with expected results queued at issue time and compared when the unit responds.
module tb_ffm_pm;
  localparam int W     = 255;
  localparam int TAG_W = 4;
  localparam logic [W-1:0] P = {W{1'b1}} - W'(18);

  typedef logic [511:0] big_t;
  localparam big_t P_BIG = big_t'(P);

  typedef struct {
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  ffm_pm_if #(.W(W), .TAG_W(TAG_W)) bus ();

  ffm_pm #(.W(W), .C(19), .DIGIT(16), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  // Reference arithmetic on 512-bit integers using plain % P.
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    big_t t;
    case (op)
      2'b00:   t = (big_t'(x) * big_t'(y)) % P_BIG;
      2'b01:   t = (big_t'(x) * big_t'(x)) % P_BIG;
      2'b10:   t = (big_t'(x) + big_t'(y)) % P_BIG;
      default: t = ((big_t'(x) % P_BIG) + P_BIG - (big_t'(y) % P_BIG)) % P_BIG;
    endcase
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_val();
    logic [255:0] t;
    int sel;
    sel = $urandom_range(0, 9);
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    case (sel)
      0:       return {W{1'b1}};
      1:       return P - W'(1);
      2:       return '0;
      3:       return P;
      default: return t[W-1:0];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one operation for a single accept edge, queues its expectation.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [TAG_W-1:0] t);
    int k = 0;
    exp_t e;
    while (bus.in_ready !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("in_ready_wait", W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = x;
    bus.b        = y;
    bus.tag      = t;
    e.res = ref_op(op, x, y);
    e.tag = t;
    sb.push_back(e);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Latency is counted in edges after the accept edge; exp_lat < 0 means only bound by max_lat.
  task automatic checkOutput(input string name, input int exp_lat, input int max_lat);
    int lat = 0;
    bit busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    chk({name, "_valid"}, W'(bus.out_valid), W'(1));
    chk({name, "_busy"}, W'(busy_ok), W'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=pending", name);
      return;
    end
    last_exp = sb.pop_front();
    chk({name, "_result"}, bus.result, last_exp.res);
    chk({name, "_tag"}, W'(bus.out_tag), W'(last_exp.tag));
    chk({name, "_canon"}, W'(bus.result < P), W'(1));
    if (exp_lat >= 0) chk({name, "_lat"}, W'(lat), W'(exp_lat));
    else              chk({name, "_latmax"}, W'(lat <= max_lat), W'(1));
  endtask

  task automatic acceptOutput(input int delay);
    repeat (delay) step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("released", W'(bus.out_valid), W'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] rop;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.tag       = '0;
    repeat (3) step();
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_result", bus.result, W'(0));
    chk("rst_out_tag", W'(bus.out_tag), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    rst = 1'b0;
    step();

    $display("[TB] directed multiply/square");
    applyStimulus(2'b00, W'(2), W'(3), 4'd5);
    checkOutput("mul_2x3", 19, 0);
    chk("mul_2x3_const", bus.result, W'(6));
    acceptOutput(0);

    applyStimulus(2'b00, P - W'(1), P - W'(1), 4'd1);
    checkOutput("mul_pm1sq", -1, 21);
    chk("mul_pm1sq_const", bus.result, W'(1));
    acceptOutput(1);

    applyStimulus(2'b01, W'(1) << 128, W'(0), 4'd2);
    checkOutput("sqr_2p128", -1, 21);
    chk("sqr_2p128_const", bus.result, W'(38));
    acceptOutput(0);

    applyStimulus(2'b00, {W{1'b1}}, W'(1), 4'd3);
    checkOutput("mul_noncanon", -1, 21);
    chk("mul_noncanon_const", bus.result, W'(18));
    acceptOutput(0);

    $display("[TB] directed add/subtract");
    applyStimulus(2'b10, P - W'(1), W'(5), 4'd4);
    checkOutput("add_wrap", 3, 0);
    chk("add_wrap_const", bus.result, W'(4));
    acceptOutput(0);

    applyStimulus(2'b11, W'(3), W'(5), 4'd6);
    checkOutput("sub_neg", 3, 0);
    chk("sub_neg_const", bus.result, P - W'(2));
    acceptOutput(0);

    applyStimulus(2'b11, W'(7), W'(7), 4'd7);
    checkOutput("sub_zero", 4, 0);
    chk("sub_zero_const", bus.result, W'(0));
    acceptOutput(0);

    $display("[TB] backpressure");
    applyStimulus(2'b00, W'(11), W'(13), 4'd9);
    checkOutput("bp", 19, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5) begin
        bus.in_valid = 1'b1;
        bus.op       = 2'b10;
        bus.a        = W'(1);
        bus.b        = W'(1);
        bus.tag      = 4'd15;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      chk("bp_hold_result", bus.result, last_exp.res);
      chk("bp_hold_tag", W'(bus.out_tag), W'(last_exp.tag));
      chk("bp_hold_valid", W'(bus.out_valid), W'(1));
      chk("bp_hold_in_ready", W'(bus.in_ready), W'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_drop_valid", W'(bus.out_valid), W'(0));
    chk("bp_in_ready", W'(bus.in_ready), W'(1));
    chk("bp_result_kept", bus.result, W'(143));
    repeat (4) step();
    chk("bp_no_ghost", W'(bus.out_valid), W'(0));
    chk("bp_no_ghost_busy", W'(bus.busy), W'(0));

    $display("[TB] reset mid-operation");
    applyStimulus(2'b00, W'(123), W'(456), 4'd3);
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_result", bus.result, W'(0));
    chk("mid_rst_out_tag", W'(bus.out_tag), W'(0));
    chk("mid_rst_busy", W'(bus.busy), W'(0));
    chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
    rst = 1'b0;
    sb.delete();
    step();
    applyStimulus(2'b00, W'(4), W'(5), 4'd6);
    checkOutput("post_rst", 19, 0);
    chk("post_rst_const", bus.result, W'(20));
    acceptOutput(0);

    $display("[TB] random regression");
    for (int n = 0; n < 1000; n++) begin
      rop = 2'($urandom_range(0, 3));
      applyStimulus(rop, rand_val(), rand_val(), 4'($urandom));
      checkOutput("rnd", -1, rop[1] ? (rop[0] ? 5 : 4) : 21);
      acceptOutput($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
